// File: rtl/inst_fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package inst_fetch_pkg;

    localparam int BIN_DIG = 32;
    localparam logic [BIN_DIG-1:0] INST_NOP = 32'h0000_0013;

    typedef struct packed {
        logic [BIN_DIG-1:0] pc;
        logic [BIN_DIG-1:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/inst_fetch_if.sv
// Fetch-stage bus: instruction-memory request/response plus the decode handoff.
interface inst_fetch_if;
    import inst_fetch_pkg::*;

    logic               imem_req_valid;
    logic               imem_req_ready;
    logic [BIN_DIG-1:0] imem_req_addr;
    logic               imem_rsp_valid;
    logic [BIN_DIG-1:0] imem_rsp_data;
    logic               inst_valid;
    logic               inst_ready;
    logic [BIN_DIG-1:0] inst_pc;
    logic [BIN_DIG-1:0] inst_data;

    // master: the fetch stage itself
    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready,
        input  imem_rsp_valid, imem_rsp_data,
        output inst_valid, inst_pc, inst_data,
        input  inst_ready
    );

    // slave: instruction memory and decode as seen from the environment
    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready,
        output imem_rsp_valid, imem_rsp_data,
        input  inst_valid, inst_pc, inst_data,
        output inst_ready
    );

endinterface

// File: rtl/inst_fetch_queue.sv
// Small in-order FIFO of {pc, inst} entries; flush empties it in one cycle.
module fetch_queue
    import inst_fetch_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         push,
    input  fetch_entry_t push_data,
    input  logic         pop,
    input  logic         flush,
    output fetch_entry_t head,
    output logic [CW-1:0] count,
    output logic         full,
    output logic         empty
);

    fetch_entry_t  mem_reg [DEPTH];
    logic [AW-1:0] wr_ptr_reg, wr_ptr_next;
    logic [AW-1:0] rd_ptr_reg, rd_ptr_next;
    logic [CW-1:0] count_reg, count_next;

    always_ff @(posedge CLK) begin
        if (push) begin
            mem_reg[wr_ptr_reg] <= push_data;
        end
    end

    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        if (flush) begin
            wr_ptr_next = '0;
            rd_ptr_next = '0;
            count_next  = '0;
        end else begin
            if (push) wr_ptr_next = wr_ptr_reg + AW'(1);
            if (pop)  rd_ptr_next = rd_ptr_reg + AW'(1);
            count_next = count_reg + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
        end
    end

    assign count = count_reg;
    assign empty = (count_reg == '0);
    assign full  = (count_reg == CW'(DEPTH));
    // Head reads as zero whenever nothing is buffered, including straight out of reset.
    assign head  = empty ? '0 : mem_reg[rd_ptr_reg];

endmodule

// File: rtl/inst_fetch.sv
// Fetch stage: PC, credit-based request issue, stale-response dropping after redirect.
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter logic [BIN_DIG-1:0] RESET_PC    = 32'h0000_0000,
    parameter int                 QUEUE_DEPTH = 4
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               redirect_valid,
    input  logic [BIN_DIG-1:0] redirect_pc,
    inst_fetch_if.master       bus
);

    localparam int CW = $clog2(QUEUE_DEPTH) + 1;
    localparam int UW = CW + 1;

    logic [BIN_DIG-1:0] pc_reg, pc_next;
    logic [BIN_DIG-1:0] rsp_pc_reg, rsp_pc_next;
    logic [CW-1:0]      outstanding_reg, outstanding_next;
    logic [CW-1:0]      drop_cnt_reg, drop_cnt_next;

    logic [BIN_DIG-1:0] redirect_target;
    logic               redirect_lsb_unused;
    logic               pop, req_valid, req_fire, rsp_keep, push;
    logic [UW-1:0]      in_use;
    logic [CW-1:0]      q_count;
    logic               q_full, q_empty;
    fetch_entry_t       q_head, q_push_data;

    assign redirect_target     = {redirect_pc[BIN_DIG-1:2], 2'b00};
    assign redirect_lsb_unused = ^redirect_pc[1:0];

    // Every issued request must have a guaranteed FIFO slot for its response.
    assign pop       = bus.inst_valid & bus.inst_ready;
    assign in_use    = {1'b0, outstanding_reg} + {1'b0, q_count} - UW'(pop);
    assign req_valid = RST & ~redirect_valid & (in_use < UW'(QUEUE_DEPTH));
    assign req_fire  = req_valid & bus.imem_req_ready;

    assign rsp_keep    = bus.imem_rsp_valid & (drop_cnt_reg == '0) & ~redirect_valid;
    assign push        = rsp_keep & ~q_full;
    assign q_push_data = '{pc: rsp_pc_reg, inst: bus.imem_rsp_data};

    always_comb begin
        pc_next          = pc_reg;
        rsp_pc_next      = rsp_pc_reg;
        outstanding_next = outstanding_reg + CW'(req_fire) - CW'(bus.imem_rsp_valid);
        drop_cnt_next    = drop_cnt_reg;
        if (redirect_valid) begin
            pc_next       = redirect_target;
            rsp_pc_next   = redirect_target;
            // Everything still in flight, minus the response arriving now, is stale.
            drop_cnt_next = outstanding_reg - CW'(bus.imem_rsp_valid);
        end else begin
            if (req_fire) pc_next = pc_reg + BIN_DIG'(4);
            if (bus.imem_rsp_valid) begin
                if (drop_cnt_reg != '0) drop_cnt_next = drop_cnt_reg - CW'(1);
                else                    rsp_pc_next   = rsp_pc_reg + BIN_DIG'(4);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            pc_reg          <= RESET_PC;
            rsp_pc_reg      <= RESET_PC;
            outstanding_reg <= '0;
            drop_cnt_reg    <= '0;
        end else begin
            pc_reg          <= pc_next;
            rsp_pc_reg      <= rsp_pc_next;
            outstanding_reg <= outstanding_next;
            drop_cnt_reg    <= drop_cnt_next;
        end
    end

    fetch_queue #(.DEPTH(QUEUE_DEPTH)) u_queue (
        .CLK       (CLK),
        .RST       (RST),
        .push      (push),
        .push_data (q_push_data),
        .pop       (pop),
        .flush     (redirect_valid),
        .head      (q_head),
        .count     (q_count),
        .full      (q_full),
        .empty     (q_empty)
    );

    assign bus.imem_req_valid = req_valid;
    assign bus.imem_req_addr  = pc_reg;
    assign bus.inst_valid     = ~q_empty;
    assign bus.inst_pc        = q_head.pc;
    assign bus.inst_data      = q_head.inst;

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch with a fixed-latency instruction memory model.
module tb_inst_fetch;
    import inst_fetch_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        redir_v;
    logic [31:0] redir_pc;
    int          n_checks = 0;
    int          n_errors = 0;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    pend_t       pend[$];
    int          cyc = 0;
    int          mem_k = 1;
    int          acc_cnt = 0;
    logic [31:0] last_addr = '0;

    always #5 clk = ~clk;

    inst_fetch_if bus();

    inst_fetch #(.RESET_PC(32'h0000_0080), .QUEUE_DEPTH(4)) dut (
        .CLK            (clk),
        .RST            (rst_n),
        .redirect_valid (redir_v),
        .redirect_pc    (redir_pc),
        .bus            (bus)
    );

    function automatic logic [31:0] tb_word(input logic [31:0] a);
        logic [31:0] i;
        i = ((a - 32'h80) >> 2) + 32'd1;
        return 32'h13 | (i << 20) | ((i & 32'h1f) << 7);
    endfunction

    // Memory: accepts on handshake, answers exactly mem_k cycles later, in order.
    always @(posedge clk) begin
        if (!rst_n) begin
            pend.delete();
            bus.imem_rsp_valid <= 1'b0;
            bus.imem_rsp_data  <= '0;
            acc_cnt            <= 0;
        end else begin
            if (bus.imem_req_valid && bus.imem_req_ready) begin
                pend.push_back('{bus.imem_req_addr, cyc + mem_k});
                acc_cnt   <= acc_cnt + 1;
                last_addr <= bus.imem_req_addr;
                $display("[%0t] mem accept addr=%h", $time, bus.imem_req_addr);
            end
            if (pend.size() > 0 && pend[0].due == cyc + 1) begin
                bus.imem_rsp_valid <= 1'b1;
                bus.imem_rsp_data  <= tb_word(pend[0].addr);
                $display("[%0t] mem respond addr=%h data=%h", $time, pend[0].addr, tb_word(pend[0].addr));
                void'(pend.pop_front());
            end else begin
                bus.imem_rsp_valid <= 1'b0;
            end
        end
        cyc <= cyc + 1;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_req_valid"}, 32'(bus.imem_req_valid), 32'd0);
        check_val({tag, "_req_addr"},  bus.imem_req_addr,       32'h80);
        check_val({tag, "_inst_valid"}, 32'(bus.inst_valid),    32'd0);
        check_val({tag, "_inst_pc"},   bus.inst_pc,             32'd0);
        check_val({tag, "_inst_data"}, bus.inst_data,           32'd0);
    endtask

    task automatic restart(input int k, input logic ready);
        rst_n              = 1'b0;
        redir_v            = 1'b0;
        bus.imem_req_ready = 1'b1;
        bus.inst_ready     = ready;
        mem_k              = k;
        repeat (2) tick();
        rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n              = 1'b0;
        redir_v            = 1'b0;
        redir_pc           = '0;
        bus.imem_req_ready = 1'b1;
        bus.inst_ready     = 1'b1;
        mem_k              = 1;

        // Reset values, then first request
        repeat (3) tick();
        check_reset_outputs("reset");
        rst_n = 1'b1;
        #1;
        check_val("first_req_valid", 32'(bus.imem_req_valid), 32'd1);
        check_val("first_req_addr",  bus.imem_req_addr,       32'h80);

        // Streaming with k=1
        tick();
        check_val("stream_latency", 32'(bus.inst_valid), 32'd0);
        tick();
        check_val("stream0_valid", 32'(bus.inst_valid), 32'd1);
        check_val("stream0_pc",    bus.inst_pc,   32'h80);
        check_val("stream0_data",  bus.inst_data, 32'h0010_0093);
        tick();
        check_val("stream1_pc",    bus.inst_pc,   32'h84);
        check_val("stream1_data",  bus.inst_data, 32'h0020_0113);
        tick();
        check_val("stream2_pc",    bus.inst_pc,   32'h88);
        check_val("stream2_data",  bus.inst_data, 32'h0030_0193);

        // Backpressure: credit stops issue at four
        restart(1, 1'b0);
        repeat (10) tick();
        check_val("bp_accepts",    32'(acc_cnt),              32'd4);
        check_val("bp_last_addr",  last_addr,                 32'h8C);
        check_val("bp_req_valid",  32'(bus.imem_req_valid),   32'd0);
        check_val("bp_head_pc",    bus.inst_pc,               32'h80);
        bus.inst_ready = 1'b1;
        #1;
        check_val("bp_resume_valid", 32'(bus.imem_req_valid), 32'd1);
        check_val("bp_resume_addr",  bus.imem_req_addr,       32'h90);
        for (int i = 0; i < 4; i++) begin
            check_val($sformatf("bp_drain%0d_pc", i),   bus.inst_pc,   32'h80 + 32'(4 * i));
            check_val($sformatf("bp_drain%0d_data", i), bus.inst_data, tb_word(32'h80 + 32'(4 * i)));
            tick();
        end
        check_val("bp_next_pc",   bus.inst_pc,   32'h90);
        check_val("bp_next_data", bus.inst_data, tb_word(32'h90));

        // Redirect with two responses in flight (k=3)
        restart(3, 1'b1);
        tick();
        tick();
        bus.imem_req_ready = 1'b0;
        redir_v  = 1'b1;
        redir_pc = 32'h203;
        #1;
        check_val("redir_accepts",   32'(acc_cnt),            32'd2);
        check_val("redir_req_valid", 32'(bus.imem_req_valid), 32'd0);
        tick();
        redir_v            = 1'b0;
        bus.imem_req_ready = 1'b1;
        #1;
        check_val("redir_new_valid", 32'(bus.imem_req_valid), 32'd1);
        check_val("redir_new_addr",  bus.imem_req_addr,       32'h200);
        for (int i = 0; i < 4; i++) begin
            check_val($sformatf("redir_drop%0d", i), 32'(bus.inst_valid), 32'd0);
            tick();
        end
        check_val("redir_head_pc",   bus.inst_pc,   32'h200);
        check_val("redir_head_data", bus.inst_data, tb_word(32'h200));

        // Redirect coincident with a response while the buffer is nearly full
        restart(3, 1'b0);
        repeat (5) tick();
        check_val("coin_pre_valid", 32'(bus.inst_valid), 32'd1);
        check_val("coin_pre_pc",    bus.inst_pc,         32'h80);
        redir_v  = 1'b1;
        redir_pc = 32'h300;
        #1;
        check_val("coin_req_valid", 32'(bus.imem_req_valid), 32'd0);
        tick();
        redir_v = 1'b0;
        #1;
        check_val("coin_flushed",   32'(bus.inst_valid),     32'd0);
        check_val("coin_new_valid", 32'(bus.imem_req_valid), 32'd1);
        check_val("coin_new_addr",  bus.imem_req_addr,       32'h300);
        repeat (3) tick();
        check_val("coin_still_empty", 32'(bus.inst_valid), 32'd0);
        tick();
        check_val("coin_head_pc",   bus.inst_pc,   32'h300);
        check_val("coin_head_data", bus.inst_data, tb_word(32'h300));

        // Request stall, then reset mid-stream
        restart(1, 1'b1);
        tick();
        bus.imem_req_ready = 1'b0;
        #1;
        for (int i = 0; i < 5; i++) begin
            check_val($sformatf("stall%0d_valid", i), 32'(bus.imem_req_valid), 32'd1);
            check_val($sformatf("stall%0d_addr", i),  bus.imem_req_addr,       32'h84);
            tick();
        end
        bus.imem_req_ready = 1'b1;
        #1;
        check_val("stall_release_addr", bus.imem_req_addr, 32'h84);
        tick();
        check_val("stall_next_addr", bus.imem_req_addr, 32'h88);
        check_val("stall_accepts",   32'(acc_cnt),      32'd2);
        tick();
        check_val("stall_head_pc",   bus.inst_pc,   32'h84);
        check_val("stall_head_data", bus.inst_data, tb_word(32'h84));
        rst_n = 1'b0;
        tick();
        check_reset_outputs("midreset");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
